// File: rtl/see_pkg.sv
// see_pkg: shared widths and loader FSM states for the SNN weight path.
package see_pkg;
    localparam int SEE_DATA_W = 32;
    localparam int SEE_ADDR_W = 10;
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;
endpackage

// File: rtl/see_weight_loader_if.sv
// see_weight_loader_if: command, stream and BRAM port-B write signals of the weight loader.
interface see_weight_loader_if import see_pkg::*; #(
    parameter int DATA_W = SEE_DATA_W,
    parameter int ADDR_W = SEE_ADDR_W
) ();
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [ADDR_W:0]   i_len;
    logic              i_s_valid;
    logic              o_s_ready;
    logic [DATA_W-1:0] i_s_data;
    logic              i_s_last;
    logic              o_wr_en_b;
    logic [ADDR_W-1:0] o_wr_addr_b;
    logic [DATA_W-1:0] o_wr_data_b;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [DATA_W-1:0] o_checksum;

    modport slave (
        input  i_start, i_base_addr, i_len, i_s_valid, i_s_data, i_s_last,
        output o_s_ready, o_wr_en_b, o_wr_addr_b, o_wr_data_b, o_busy, o_done, o_err, o_checksum
    );
    modport master (
        output i_start, i_base_addr, i_len, i_s_valid, i_s_data, i_s_last,
        input  o_s_ready, o_wr_en_b, o_wr_addr_b, o_wr_data_b, o_busy, o_done, o_err, o_checksum
    );
endinterface

// File: rtl/see_wr_stage.sv
// see_wr_stage: one-cycle write-issue register; addr/data hold when no write is issued.
module see_wr_stage import see_pkg::*; #(
    parameter int DATA_W = SEE_DATA_W,
    parameter int ADDR_W = SEE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);
    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q <= en_i;
            if (en_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign en_o   = en_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
endmodule

// File: rtl/see_weight_loader.sv
// see_weight_loader: writes a framed valid/ready word stream into consecutive BRAM port-B
// addresses, reporting completion, framing error and a wrapping checksum.
module see_weight_loader import see_pkg::*; #(
    parameter int DATA_W = SEE_DATA_W,
    parameter int ADDR_W = SEE_ADDR_W
) (
    input logic           clk,
    input logic           rst_n,
    see_weight_loader_if.slave bus
);
    localparam logic [1:0] IDLE = LD_IDLE;
    localparam logic [1:0] LOAD = LD_LOAD;
    localparam logic [1:0] DONE = LD_DONE;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d, done_q;
    logic              beat, len_zero, len_over, cnt_one;

    always_comb begin
        beat     = bus.i_s_valid && state_q == LOAD;
        len_zero = bus.i_len == '0;
        len_over = bus.i_len > DEPTH;
        cnt_one  = cnt_q == (ADDR_W+1)'(1);
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        err_d    = err_q;
        if (state_q == IDLE && bus.i_start) begin
            state_d = (len_zero || len_over) ? DONE : LOAD;
            addr_d  = bus.i_base_addr;
            cnt_d   = bus.i_len;
            sum_d   = '0;
            err_d   = len_over;
        end else if (beat) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            sum_d  = sum_q + bus.i_s_data;
            // Frame ends on whichever comes first; a mismatch between the two is a framing error.
            if (cnt_one || bus.i_s_last) begin
                state_d = DONE;
                err_d   = cnt_one != bus.i_s_last;
            end
        end else if (state_q != LOAD) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            done_q  <= state_q == DONE;
        end
    end

    see_wr_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (beat),
        .addr_i (addr_q),
        .data_i (bus.i_s_data),
        .en_o   (bus.o_wr_en_b),
        .addr_o (bus.o_wr_addr_b),
        .data_o (bus.o_wr_data_b)
    );

    assign bus.o_s_ready  = state_q == LOAD;
    assign bus.o_busy     = state_q != IDLE;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_checksum = sum_q;
endmodule

// File: tb/tb_see_weight_loader.sv
// tb_see_weight_loader: directed stimulus with write/done scoreboards and a port-A BRAM readback model.
module tb_see_weight_loader;
    typedef struct {logic [9:0] a; logic [31:0] d; int c;} wr_t;
    typedef struct {logic e; logic [31:0] s; int c;} dn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    wr_t  wq[$];
    dn_t  dq[$];
    logic [31:0] dat [0:1023];
    logic [31:0] mem [0:1023];
    logic [9:0]  ra = '0;
    logic [31:0] rd;
    logic [31:0] rb_tab [8] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                                32'h00000001, 32'h12345678, 32'hDEADBEEF, 32'hFFFF0001};

    see_weight_loader_if bus ();
    see_weight_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.o_wr_en_b) mem[bus.o_wr_addr_b] <= bus.o_wr_data_b;
    always @(posedge clk) rd <= mem[ra];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (bus.o_wr_en_b) begin
            if (wq.size() == 0) chk("unexpected_write", {22'd0, bus.o_wr_addr_b, bus.o_wr_data_b}, 64'hDEAD);
            else begin
                w = wq.pop_front();
                chk("wr_addr", bus.o_wr_addr_b, w.a);
                chk("wr_data", bus.o_wr_data_b, w.d);
                chk("wr_cycle", cyc, w.c);
            end
        end
        if (bus.o_done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                d = dq.pop_front();
                chk("done_err", bus.o_err, d.e);
                chk("done_checksum", bus.o_checksum, d.s);
                chk("done_cycle", cyc, d.c);
                chk("done_busy", bus.o_busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [9:0] b, input logic [10:0] l, output int e);
        bus.i_start = 1'b1;
        bus.i_base_addr = b;
        bus.i_len = l;
        tick();
        e = cyc;
        bus.i_start = 1'b0;
    endtask

    task automatic stream(input logic [9:0] base, input int i0, input int n, input int last_at,
                          input bit toggle, output int last_cyc);
        int   i = i0;
        int   g = 0;
        logic rdy;
        wr_t  w;
        last_cyc = 0;
        while (i < n && g < 4000) begin
            bus.i_s_valid = toggle ? (g % 2 == 0) : 1'b1;
            bus.i_s_data = dat[i];
            bus.i_s_last = (i + 1 == last_at);
            rdy = bus.o_s_ready;
            tick();
            if (bus.i_s_valid && rdy) begin
                w.a = base + 10'(i);
                w.d = dat[i];
                w.c = cyc;
                wq.push_back(w);
                last_cyc = cyc;
                i++;
            end
            g++;
        end
        bus.i_s_valid = 1'b0;
        bus.i_s_last = 1'b0;
        if (i < n) chk("stream_timeout", i, n);
    endtask

    task automatic exp_done(input logic e, input logic [31:0] s, input int c);
        dn_t d;
        d.e = e;
        d.s = s;
        d.c = c;
        dq.push_back(d);
    endtask

    task automatic settle();
        repeat (4) tick();
        chk("writes_drained", wq.size(), 0);
        chk("dones_drained", dq.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ready"}, bus.o_s_ready, 0);
        chk({nm, "_wr_en"}, bus.o_wr_en_b, 0);
        chk({nm, "_wr_addr"}, bus.o_wr_addr_b, 0);
        chk({nm, "_wr_data"}, bus.o_wr_data_b, 0);
        chk({nm, "_busy"}, bus.o_busy, 0);
        chk({nm, "_done"}, bus.o_done, 0);
        chk({nm, "_err"}, bus.o_err, 0);
        chk({nm, "_checksum"}, bus.o_checksum, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, lc;
        bus.i_start = 1'b0;
        bus.i_base_addr = '0;
        bus.i_len = '0;
        bus.i_s_valid = 1'b0;
        bus.i_s_data = '0;
        bus.i_s_last = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // basic load
        for (int i = 0; i < 4; i++) dat[i] = 32'(i + 1);
        cmd(10'h010, 11'd4, e);
        chk("basic_busy", bus.o_busy, 1);
        chk("basic_ready", bus.o_s_ready, 1);
        stream(10'h010, 0, 4, 4, 1'b0, lc);
        chk("basic_no_bubbles", lc - e, 4);
        exp_done(1'b0, 32'd10, lc + 1);
        settle();
        chk("basic_idle_ready", bus.o_s_ready, 0);

        // wrap with alternating valid
        for (int i = 0; i < 4; i++) dat[i] = 32'(i + 5);
        cmd(10'h3FE, 11'd4, e);
        stream(10'h3FE, 0, 4, 4, 1'b1, lc);
        exp_done(1'b0, 32'd26, lc + 1);
        settle();

        // short frame: last on 2nd of 3
        dat[0] = 32'h10;
        dat[1] = 32'h20;
        cmd(10'h080, 11'd3, e);
        stream(10'h080, 0, 2, 2, 1'b0, lc);
        exp_done(1'b1, 32'h30, lc + 1);
        settle();

        // long frame: no last on final word, surplus words refused
        dat[0] = 32'hA;
        dat[1] = 32'hB;
        cmd(10'h0C0, 11'd2, e);
        stream(10'h0C0, 0, 2, 0, 1'b0, lc);
        exp_done(1'b1, 32'h15, lc + 1);
        bus.i_s_valid = 1'b1;
        bus.i_s_data = 32'hC;
        repeat (3) begin
            tick();
            chk("surplus_ready", bus.o_s_ready, 0);
        end
        bus.i_s_valid = 1'b0;
        settle();

        // zero length
        cmd(10'h055, 11'd0, e);
        chk("len0_busy", bus.o_busy, 1);
        chk("len0_ready", bus.o_s_ready, 0);
        exp_done(1'b0, 32'd0, e + 1);
        settle();

        // oversize
        cmd(10'h055, 11'd1025, e);
        exp_done(1'b1, 32'd0, e + 1);
        settle();

        // full depth
        for (int i = 0; i < 1024; i++) dat[i] = 32'(i);
        cmd(10'h000, 11'd1024, e);
        stream(10'h000, 0, 1024, 1024, 1'b0, lc);
        chk("full_no_bubbles", lc - e, 1024);
        exp_done(1'b0, 32'd523776, lc + 1);
        settle();

        // start during LOAD is ignored
        dat[0] = 32'h11;
        dat[1] = 32'h22;
        dat[2] = 32'h33;
        dat[3] = 32'h44;
        cmd(10'h100, 11'd4, e);
        stream(10'h100, 0, 1, 0, 1'b0, lc);
        bus.i_start = 1'b1;
        bus.i_base_addr = 10'h200;
        bus.i_len = 11'd1;
        tick();
        bus.i_start = 1'b0;
        chk("start_in_load_ready", bus.o_s_ready, 1);
        stream(10'h100, 1, 4, 4, 1'b0, lc);
        exp_done(1'b0, 32'hAA, lc + 1);
        settle();

        // reset mid-LOAD after two beats
        for (int i = 0; i < 4; i++) dat[i] = 32'(i + 1);
        cmd(10'h300, 11'd4, e);
        stream(10'h300, 0, 2, 0, 1'b0, lc);
        rst_n = 1'b0;
        bus.i_s_valid = 1'b1;
        bus.i_s_data = dat[2];
        tick();
        chk_zero("midreset");
        rst_n = 1'b1;
        bus.i_s_valid = 1'b0;
        settle();

        // signed words then port-A readback
        for (int i = 0; i < 8; i++) dat[i] = rb_tab[i];
        cmd(10'h040, 11'd8, e);
        stream(10'h040, 0, 8, 8, 1'b0, lc);
        exp_done(1'b0, 32'hF0E11567, lc + 1);
        settle();
        for (int i = 0; i < 8; i++) begin
            ra = 10'h040 + 10'(i);
            tick();
            chk("readback", rd, rb_tab[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
